// File: rtl/mdr_access_if.sv
// Request/memory-control bundle between the control unit, the MDR access
// sequencer and the external memory/MDR.
interface mdr_access_if #(
   parameter int AW = 8
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          du_req;
   logic          du_we;
   logic [AW-1:0] du_addr;
   logic          alu_load;
   logic [AW-1:0] mem_addr;
   logic          mem_en;
   logic          M_read;
   logic          M_write;
   logic          set;
   logic          if_done;
   logic          du_done;
   logic          busy;

   modport master (
      output if_req, if_addr, du_req, du_we, du_addr, alu_load,
      input  mem_addr, mem_en, M_read, M_write, set, if_done, du_done, busy
   );

   modport slave (
      input  if_req, if_addr, du_req, du_we, du_addr, alu_load,
      output mem_addr, mem_en, M_read, M_write, set, if_done, du_done, busy
   );
endinterface

// File: rtl/mdr_access_ctrl.sv
// Round-robin memory-port sequencer for IF/DU with programmable wait states
// and deferred MDR load-from-ALU strobes.
//
// state | meaning
// IDLE  | issue pending ALU load, else arbitrate and latch address
// ADDR  | address phase, memory enabled
// WAIT  | WAIT_CYCLES wait states, memory enabled
// XFER  | single transfer cycle, M_read or M_write
// DONE  | completion pulse to granted side, pointer flips
module mdr_access_ctrl #(
   parameter int AW          = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   mdr_access_if.slave  bus
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_XFER = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   logic [2:0]    state_q, state_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic          we_q, we_d;
   logic          gnt_du_q, gnt_du_d;
   logic          ptr_du_q, ptr_du_d;
   logic          load_pend_q, load_pend_d;
   logic [3:0]    wait_cnt_q, wait_cnt_d;
   logic          set_c;
   logic          pick_du;

   // DU wins only if IF is absent or the pointer currently favours DU
   assign pick_du = bus.du_req && (!bus.if_req || ptr_du_q);

   always_comb begin
      state_d     = state_q;
      mem_addr_d  = mem_addr_q;
      we_d        = we_q;
      gnt_du_d    = gnt_du_q;
      ptr_du_d    = ptr_du_q;
      load_pend_d = load_pend_q;
      wait_cnt_d  = wait_cnt_q;
      set_c       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.alu_load || load_pend_q) begin
               set_c       = 1'b1;
               load_pend_d = 1'b0;
            end else if (bus.if_req || bus.du_req) begin
               gnt_du_d   = pick_du;
               mem_addr_d = pick_du ? bus.du_addr : bus.if_addr;
               we_d       = pick_du && bus.du_we;
               state_d    = S_ADDR;
            end
         end
         S_ADDR: begin
            wait_cnt_d = WAIT_LOAD;
            state_d    = (WAIT_CYCLES > 0) ? S_WAIT : S_XFER;
         end
         S_WAIT: begin
            if (wait_cnt_q == 4'd0) begin
               state_d = S_XFER;
            end else begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end
         end
         S_XFER: state_d = S_DONE;
         S_DONE: begin
            ptr_du_d = !ptr_du_q;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // a load requested mid-access is held until the port is back in IDLE
      if ((state_q != S_IDLE) && bus.alu_load) begin
         load_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         mem_addr_q  <= '0;
         we_q        <= 1'b0;
         gnt_du_q    <= 1'b0;
         ptr_du_q    <= 1'b0;
         load_pend_q <= 1'b0;
         wait_cnt_q  <= 4'd0;
      end else begin
         state_q     <= state_d;
         mem_addr_q  <= mem_addr_d;
         we_q        <= we_d;
         gnt_du_q    <= gnt_du_d;
         ptr_du_q    <= ptr_du_d;
         load_pend_q <= load_pend_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_en   = (state_q == S_ADDR) || (state_q == S_WAIT) || (state_q == S_XFER);
   assign bus.M_read   = (state_q == S_XFER) && !we_q;
   assign bus.M_write  = (state_q == S_XFER) && we_q;
   assign bus.set      = set_c;
   assign bus.if_done  = (state_q == S_DONE) && !gnt_du_q;
   assign bus.du_done  = (state_q == S_DONE) && gnt_du_q;
   assign bus.busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mdr_access_ctrl.sv
// Self-checking bench: three controllers (WAIT_CYCLES 1, 0, 4) checked against
// a transaction-level timing/arbitration model.
module tb_mdr_access_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic       if_req [3];
   logic       du_req [3];
   logic       du_we [3];
   logic       alu_load [3];
   logic [7:0] if_addr [3];
   logic [7:0] du_addr [3];
   logic [7:0] mem_addr [3];
   logic       mem_en [3];
   logic       M_read [3];
   logic       M_write [3];
   logic       set [3];
   logic       if_done [3];
   logic       du_done [3];
   logic       busy [3];

   int n_chk  = 0;
   int n_fail = 0;
   bit fav_du [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mdr_access_if #(.AW(8)) bus ();
      assign bus.if_req   = if_req[g];
      assign bus.if_addr  = if_addr[g];
      assign bus.du_req   = du_req[g];
      assign bus.du_we    = du_we[g];
      assign bus.du_addr  = du_addr[g];
      assign bus.alu_load = alu_load[g];
      assign mem_addr[g]  = bus.mem_addr;
      assign mem_en[g]    = bus.mem_en;
      assign M_read[g]    = bus.M_read;
      assign M_write[g]   = bus.M_write;
      assign set[g]       = bus.set;
      assign if_done[g]   = bus.if_done;
      assign du_done[g]   = bus.du_done;
      assign busy[g]      = bus.busy;
      mdr_access_ctrl #(
         .AW(8),
         .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 0 : 4))
      ) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );
   end

   function automatic int wc(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 0 : 4);
   endfunction

   task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
      end
   endtask

   task automatic chk_idle(input int d, input bit exp_set);
      chk("idle_busy", d, 32'(busy[d]), 0);
      chk("idle_mem_en", d, 32'(mem_en[d]), 0);
      chk("idle_M_read", d, 32'(M_read[d]), 0);
      chk("idle_M_write", d, 32'(M_write[d]), 0);
      chk("idle_if_done", d, 32'(if_done[d]), 0);
      chk("idle_du_done", d, 32'(du_done[d]), 0);
      chk("idle_set", d, 32'(set[d]), 32'(exp_set));
   endtask

   // Follows one granted access from its first busy cycle (k=1) to the
   // IDLE cycle after DONE (k=W+4), checking every cycle against the
   // expected timeline: mem_en for k<=W+2, strobe at k=W+2, done at k=W+3.
   task automatic watch(input int d, input bit du_side, input bit we, input logic [7:0] addr,
                        input logic [1:0] drop, input bit scramble,
                        input logic [15:0] alu_mask, input bit exp_set_idle);
      int w;
      w = wc(d);
      for (int k = 1; k <= w + 4; k++) begin
         @(posedge clk);
         #1;
         alu_load[d] = alu_mask[k];
         if (scramble && k == 2) begin
            if_addr[d] = addr ^ 8'h30;
            du_addr[d] = addr ^ 8'h30;
            du_we[d]   = !we;
            if ($urandom_range(1, 0) == 1) begin
               if_req[d] = 1'b0;
               du_req[d] = 1'b0;
            end
         end
         #1;
         if (k <= w + 3) begin
            chk("busy", d, 32'(busy[d]), 1);
            chk("mem_en", d, 32'(mem_en[d]), 32'(k <= w + 2));
            chk("M_read", d, 32'(M_read[d]), 32'((k == w + 2) && !we));
            chk("M_write", d, 32'(M_write[d]), 32'((k == w + 2) && we));
            chk("if_done", d, 32'(if_done[d]), 32'((k == w + 3) && !du_side));
            chk("du_done", d, 32'(du_done[d]), 32'((k == w + 3) && du_side));
            chk("mem_addr", d, 32'(mem_addr[d]), 32'(addr));
            chk("set_busy", d, 32'(set[d]), 0);
         end else begin
            chk_idle(d, exp_set_idle);
         end
         if (k == w + 3) begin
            fav_du[d] = !fav_du[d];
            if (drop[0]) if_req[d] = 1'b0;
            if (drop[1]) du_req[d] = 1'b0;
         end
      end
      alu_load[d] = 1'b0;
   endtask

   task automatic single(input int d, input bit du_side, input bit we, input logic [7:0] addr,
                         input bit scr);
      if (du_side) begin
         du_req[d]  = 1'b1;
         du_addr[d] = addr;
         du_we[d]   = we;
      end else begin
         if_req[d]  = 1'b1;
         if_addr[d] = addr;
      end
      watch(d, du_side, du_side && we, addr, 2'b11, scr, 16'h0000, 1'b0);
   endtask

   task automatic contend(input int d, input int n, input logic [7:0] a, input logic [7:0] b,
                          input bit we);
      bit s;
      if_req[d]  = 1'b1;
      du_req[d]  = 1'b1;
      if_addr[d] = a;
      du_addr[d] = b;
      du_we[d]   = we;
      for (int g = 0; g < n; g++) begin
         s = fav_du[d];
         watch(d, s, s && we, s ? b : a, (g == n - 1) ? 2'b11 : 2'b00, 1'b0, 16'h0000, 1'b0);
      end
   endtask

   initial begin
      bit s;
      int d;
      bit side;
      bit we;
      logic [7:0] a;
      for (int i = 0; i < 3; i++) begin
         if_req[i] = 1'b0; du_req[i] = 1'b0; du_we[i] = 1'b0; alu_load[i] = 1'b0;
         if_addr[i] = 8'h00; du_addr[i] = 8'h00; fav_du[i] = 1'b0;
      end

      // reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      for (int i = 0; i < 3; i++) begin
         chk_idle(i, 1'b0);
         chk("rst_mem_addr", i, 32'(mem_addr[i]), 0);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #2;

      // contention from reset: IF, DU, IF, DU
      contend(0, 4, 8'h11, 8'hE2, 1'b1);
      contend(1, 4, 8'h33, 8'h44, 1'b0);
      contend(2, 4, 8'h5C, 8'hC5, 1'b1);

      // directed single accesses
      single(0, 1'b0, 1'b0, 8'h3C, 1'b0);
      single(1, 1'b1, 1'b1, 8'hA5, 1'b0);
      single(2, 1'b1, 1'b0, 8'h10, 1'b1);

      // ALU load during WAIT with a competing request pending
      s = fav_du[0];
      if_req[0] = 1'b1; if_addr[0] = 8'h5A;
      du_req[0] = 1'b1; du_addr[0] = 8'hB4; du_we[0] = 1'b1;
      watch(0, s, s, s ? 8'hB4 : 8'h5A, s ? 2'b10 : 2'b01, 1'b0, 16'h0004, 1'b1);
      @(posedge clk);
      #2;
      chk_idle(0, 1'b0);
      watch(0, !s, !s, !s ? 8'hB4 : 8'h5A, 2'b11, 1'b0, 16'h0000, 1'b0);

      // two ALU pulses during one access collapse to one set
      if_req[2] = 1'b1; if_addr[2] = 8'h66;
      watch(2, 1'b0, 1'b0, 8'h66, 2'b11, 1'b0, 16'h0082, 1'b1);
      @(posedge clk);
      #2;
      chk_idle(2, 1'b0);

      // ALU load in IDLE wins over a simultaneous request
      alu_load[1] = 1'b1; if_req[1] = 1'b1; if_addr[1] = 8'h77;
      #1;
      chk("idle_alu_set", 1, 32'(set[1]), 1);
      chk("idle_alu_busy", 1, 32'(busy[1]), 0);
      @(posedge clk);
      #1;
      alu_load[1] = 1'b0;
      #1;
      chk_idle(1, 1'b0);
      watch(1, 1'b0, 1'b0, 8'h77, 2'b11, 1'b0, 16'h0000, 1'b0);

      // randomized traffic
      for (int it = 0; it < 30; it++) begin
         d    = int'($urandom_range(2, 0));
         side = 1'($urandom);
         we   = side && 1'($urandom);
         a    = 8'($urandom);
         if ($urandom_range(3, 0) == 0) contend(d, int'($urandom_range(3, 2)), a, ~a, we);
         else single(d, side, we, a, 1'($urandom));
      end

      // asynchronous reset in the middle of a DU write transfer
      du_req[1] = 1'b1; du_we[1] = 1'b1; du_addr[1] = 8'hA5;
      @(posedge clk);
      #2;
      @(posedge clk);
      #2;
      chk("pre_rst_M_write", 1, 32'(M_write[1]), 1);
      rst_n = 1'b0;
      #1;
      chk("rst_M_write", 1, 32'(M_write[1]), 0);
      chk("rst_mem_en", 1, 32'(mem_en[1]), 0);
      chk("rst_busy", 1, 32'(busy[1]), 0);
      for (int c = 0; c < 2; c++) begin
         @(posedge clk);
         #2;
         chk("rst_du_done", 1, 32'(du_done[1]), 0);
      end
      du_req[1] = 1'b0;
      for (int i = 0; i < 3; i++) fav_du[i] = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #2;
      for (int i = 0; i < 3; i++) begin
         chk_idle(i, 1'b0);
         chk("post_rst_mem_addr", i, 32'(mem_addr[i]), 0);
      end
      single(1, 1'b1, 1'b1, 8'hA5, 1'b0);
      contend(0, 2, 8'h01, 8'h02, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
